countdown_timer: RTL and testbench



---
 rtl/countdown_timer_if.sv | 25 ++
 rtl/countdown_timer.sv | 142 ++++++++++++++
 tb/tb_countdown_timer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Button/pulse inputs and BCD display outputs of the countdown timer.
// The timer is the slave; the top level (or bench) drives it as master.
interface countdown_timer_if;
  logic       EN1HZ;
  logic       START;
  logic       MINUP;
  logic       SECUP;
  logic       CLR;
  logic [2:0] MINH;
  logic [3:0] MINL;
  logic [2:0] SECH;
  logic [3:0] SECL;
  logic       RUNNING;
  logic       ALARM;

  modport slave (
    input  EN1HZ, START, MINUP, SECUP, CLR,
    output MINH, MINL, SECH, SECL, RUNNING, ALARM
  );

  modport master (
    output EN1HZ, START, MINUP, SECUP, CLR,
    input  MINH, MINL, SECH, SECL, RUNNING, ALARM
  );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS kitchen timer counting down in BCD on the 1 Hz pulse, with a
// self-expiring alarm phase once it reaches 00:00.
module countdown_timer #(
  parameter int ALARM_SECS = 5
) (
  input  logic               CLK,
  input  logic               RST,
  countdown_timer_if.slave   bus
);

  typedef enum logic [1:0] {SET, RUN, PAUSE, ALM} state_t;

  state_t     state_q, state_d;
  logic [2:0] minh_q, minh_d, sech_q, sech_d;
  logic [3:0] minl_q, minl_d, secl_q, secl_d;
  logic [3:0] almCnt_q, almCnt_d;
  logic       running_q, running_d, alarm_q, alarm_d;
  logic       timeZero;

  assign timeZero = (minh_q == 3'd0) && (minl_q == 4'd0) &&
                    (sech_q == 3'd0) && (secl_q == 4'd0);

  // START takes the whole cycle, so MINUP/SECUP/EN1HZ never act alongside it.
  always_comb begin
    state_d  = state_q;
    minh_d   = minh_q;
    minl_d   = minl_q;
    sech_d   = sech_q;
    secl_d   = secl_q;
    almCnt_d = almCnt_q;

    if (bus.CLR) begin
      state_d  = SET;
      minh_d   = 3'd0;
      minl_d   = 4'd0;
      sech_d   = 3'd0;
      secl_d   = 4'd0;
      almCnt_d = 4'd0;
    end else begin
      case (state_q)
        SET: begin
          if (bus.START) begin
            if (!timeZero) state_d = RUN;
          end else begin
            if (bus.MINUP) begin
              if (minl_q == 4'd9) begin
                minl_d = 4'd0;
                minh_d = (minh_q == 3'd5) ? 3'd0 : minh_q + 3'd1;
              end else begin
                minl_d = minl_q + 4'd1;
              end
            end
            if (bus.SECUP) begin
              if (secl_q == 4'd9) begin
                secl_d = 4'd0;
                sech_d = (sech_q == 3'd5) ? 3'd0 : sech_q + 3'd1;
              end else begin
                secl_d = secl_q + 4'd1;
              end
            end
          end
        end
        RUN: begin
          if (bus.START) begin
            state_d = PAUSE;
          end else if (bus.EN1HZ) begin
            if (secl_q != 4'd0) begin
              secl_d = secl_q - 4'd1;
            end else if (sech_q != 3'd0) begin
              sech_d = sech_q - 3'd1;
              secl_d = 4'd9;
            end else begin
              sech_d = 3'd5;
              secl_d = 4'd9;
              if (minl_q != 4'd0) begin
                minl_d = minl_q - 4'd1;
              end else begin
                minl_d = 4'd9;
                minh_d = minh_q - 3'd1;
              end
            end
            if ((minh_d == 3'd0) && (minl_d == 4'd0) &&
                (sech_d == 3'd0) && (secl_d == 4'd0)) begin
              state_d  = ALM;
              almCnt_d = 4'(ALARM_SECS);
            end
          end
        end
        PAUSE: begin
          if (bus.START) state_d = RUN;
        end
        ALM: begin
          if (bus.START) begin
            state_d  = SET;
            almCnt_d = 4'd0;
          end else if (bus.EN1HZ) begin
            if (almCnt_q <= 4'd1) begin
              state_d  = SET;
              almCnt_d = 4'd0;
            end else begin
              almCnt_d = almCnt_q - 4'd1;
            end
          end
        end
        default: state_d = SET;
      endcase
    end

    running_d = (state_d == RUN);
    alarm_d   = (state_d == ALM);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= SET;
      minh_q    <= 3'd0;
      minl_q    <= 4'd0;
      sech_q    <= 3'd0;
      secl_q    <= 4'd0;
      almCnt_q  <= 4'd0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      minh_q    <= minh_d;
      minl_q    <= minl_d;
      sech_q    <= sech_d;
      secl_q    <= secl_d;
      almCnt_q  <= almCnt_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
    end
  end

  assign bus.MINH    = minh_q;
  assign bus.MINL    = minl_q;
  assign bus.SECH    = sech_q;
  assign bus.SECL    = secl_q;
  assign bus.RUNNING = running_q;
  assign bus.ALARM   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random pulses, all
// checked against a seconds-based behavioural model of the timer.
module tb_countdown_timer;

  localparam int ALARM_SECS = 5;
  localparam int M_SET = 0, M_RUN = 1, M_PAUSE = 2, M_ALM = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int mMin, mSec, mState, mAlm;

  countdown_timer_if bus ();

  countdown_timer #(.ALARM_SECS(ALARM_SECS)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Display packing: MINH,MINL,SECH,SECL,RUNNING,ALARM.
  function automatic logic [15:0] expVec(int mm, int ss, logic run, logic alm);
    return {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10), run, alm};
  endfunction

  function automatic logic [15:0] modelVec();
    return expVec(mMin, mSec, mState == M_RUN, mState == M_ALM);
  endfunction

  function automatic logic [15:0] dutVec();
    return {bus.MINH, bus.MINL, bus.SECH, bus.SECL, bus.RUNNING, bus.ALARM};
  endfunction

  task automatic modelReset();
    mMin = 0; mSec = 0; mState = M_SET; mAlm = 0;
  endtask

  // Time is held as plain minutes/seconds; a tick subtracts one second of total time.
  task automatic modelStep(bit en, bit st, bit mu, bit su, bit cl);
    int t;
    if (cl) begin
      mMin = 0; mSec = 0; mState = M_SET; mAlm = 0;
    end else if (mState == M_SET) begin
      if (st) begin
        if (mMin * 60 + mSec > 0) mState = M_RUN;
      end else begin
        if (mu) mMin = (mMin + 1) % 60;
        if (su) mSec = (mSec + 1) % 60;
      end
    end else if (mState == M_RUN) begin
      if (st) mState = M_PAUSE;
      else if (en) begin
        t = mMin * 60 + mSec - 1;
        mMin = t / 60;
        mSec = t % 60;
        if (t == 0) begin mState = M_ALM; mAlm = ALARM_SECS; end
      end
    end else if (mState == M_PAUSE) begin
      if (st) mState = M_RUN;
    end else begin
      if (st) begin mState = M_SET; mAlm = 0; end
      else if (en) begin
        mAlm = mAlm - 1;
        if (mAlm == 0) mState = M_SET;
      end
    end
  endtask

  task automatic applyStimulus(bit en, bit st, bit mu, bit su, bit cl);
    @(negedge clk);
    bus.EN1HZ = en; bus.START = st; bus.MINUP = mu; bus.SECUP = su; bus.CLR = cl;
    @(posedge clk);
    #1;
    bus.EN1HZ = 1'b0; bus.START = 1'b0; bus.MINUP = 1'b0; bus.SECUP = 1'b0; bus.CLR = 1'b0;
    modelStep(en, st, mu, su, cl);
  endtask

  task automatic applyReset(int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic tick();
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    applyReset(2);
    checks++;
    if (dutVec() !== expVec(0, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL reset_values got %h want %h", dutVec(), expVec(0, 0, 0, 0));
    end
    repeat (10) tick();
    checks++;
    if (dutVec() !== modelVec()) begin
      errors++; $display("[TB] FAIL reset_idle got %h want %h", dutVec(), modelVec());
    end
  endtask

  task automatic test_set_run();
    repeat (3) applyStimulus(0, 0, 1, 0, 0);
    repeat (61) applyStimulus(0, 0, 0, 1, 0);
    checks++;
    if (dutVec() !== expVec(3, 1, 0, 0)) begin
      errors++; $display("[TB] FAIL set_0301 got %h want %h", dutVec(), expVec(3, 1, 0, 0));
    end
    applyStimulus(0, 1, 0, 0, 0);
    checks++;
    if (dutVec() !== modelVec()) begin
      errors++; $display("[TB] FAIL start_run got %h want %h", dutVec(), modelVec());
    end
    tick();
    checks++;
    if (dutVec() !== expVec(3, 0, 1, 0)) begin
      errors++; $display("[TB] FAIL dec_0300 got %h want %h", dutVec(), expVec(3, 0, 1, 0));
    end
    tick();
    checks++;
    if (dutVec() !== modelVec() || bus.SECH !== 3'd5 || bus.SECL !== 4'd9) begin
      errors++; $display("[TB] FAIL wrap_0259 got %h want %h", dutVec(), modelVec());
    end
  endtask

  task automatic test_alarm();
    applyStimulus(0, 0, 0, 0, 1);
    repeat (2) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    tick();
    checks++;
    if (dutVec() !== expVec(0, 1, 1, 0)) begin
      errors++; $display("[TB] FAIL alarm_0001 got %h want %h", dutVec(), expVec(0, 1, 1, 0));
    end
    applyStimulus(1, 0, 0, 0, 0);
    checks++;
    if (dutVec() !== expVec(0, 0, 0, 1)) begin
      errors++; $display("[TB] FAIL alarm_enter got %h want %h", dutVec(), expVec(0, 0, 0, 1));
    end
    applyStimulus(0, 0, 0, 0, 0);
    repeat (ALARM_SECS - 1) tick();
    checks++;
    if (dutVec() !== modelVec() || bus.ALARM !== 1'b1) begin
      errors++; $display("[TB] FAIL alarm_hold got %h want %h", dutVec(), modelVec());
    end
    tick();
    checks++;
    if (dutVec() !== expVec(0, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL alarm_expire got %h want %h", dutVec(), expVec(0, 0, 0, 0));
    end
    repeat (2) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    repeat (2) tick();
    applyStimulus(0, 1, 0, 0, 0);
    checks++;
    if (dutVec() !== expVec(0, 0, 0, 0) || dutVec() !== modelVec()) begin
      errors++; $display("[TB] FAIL alarm_ack got %h want %h", dutVec(), expVec(0, 0, 0, 0));
    end
  endtask

  task automatic test_pause();
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    tick();
    checks++;
    if (dutVec() !== expVec(0, 59, 1, 0)) begin
      errors++; $display("[TB] FAIL pause_run got %h want %h", dutVec(), expVec(0, 59, 1, 0));
    end
    applyStimulus(0, 1, 0, 0, 0);
    repeat (5) tick();
    applyStimulus(0, 0, 1, 1, 0);
    checks++;
    if (dutVec() !== expVec(0, 59, 0, 0)) begin
      errors++; $display("[TB] FAIL pause_frozen got %h want %h", dutVec(), expVec(0, 59, 0, 0));
    end
    applyStimulus(0, 1, 0, 0, 0);
    tick();
    checks++;
    if (dutVec() !== expVec(0, 58, 1, 0)) begin
      errors++; $display("[TB] FAIL pause_resume got %h want %h", dutVec(), expVec(0, 58, 1, 0));
    end
  endtask

  task automatic test_edges();
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0);
    checks++;
    if (dutVec() !== expVec(0, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL start_zero got %h want %h", dutVec(), expVec(0, 0, 0, 0));
    end
    repeat (59) applyStimulus(0, 0, 1, 0, 0);
    checks++;
    if (dutVec() !== expVec(59, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL min_59 got %h want %h", dutVec(), expVec(59, 0, 0, 0));
    end
    applyStimulus(0, 0, 1, 0, 0);
    checks++;
    if (dutVec() !== expVec(0, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL min_wrap got %h want %h", dutVec(), expVec(0, 0, 0, 0));
    end
    applyStimulus(0, 0, 1, 1, 0);
    checks++;
    if (dutVec() !== expVec(1, 1, 0, 0)) begin
      errors++; $display("[TB] FAIL both_up got %h want %h", dutVec(), expVec(1, 1, 0, 0));
    end
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0);
    checks++;
    if (dutVec() !== expVec(1, 1, 1, 0)) begin
      errors++; $display("[TB] FAIL minup_in_run got %h want %h", dutVec(), expVec(1, 1, 1, 0));
    end
  endtask

  task automatic test_coincident();
    applyStimulus(0, 0, 0, 0, 1);
    repeat (2) applyStimulus(0, 0, 1, 0, 0);
    repeat (30) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1);
    checks++;
    if (dutVec() !== expVec(0, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL clr_start got %h want %h", dutVec(), expVec(0, 0, 0, 0));
    end
    repeat (10) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checks++;
    if (dutVec() !== expVec(0, 10, 0, 0)) begin
      errors++; $display("[TB] FAIL start_en got %h want %h", dutVec(), expVec(0, 10, 0, 0));
    end
    applyStimulus(0, 1, 0, 0, 0);
    tick();
    applyReset(1);
    checks++;
    if (dutVec() !== expVec(0, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL rst_mid_run got %h want %h", dutVec(), expVec(0, 0, 0, 0));
    end
    tick();
    checks++;
    if (dutVec() !== modelVec()) begin
      errors++; $display("[TB] FAIL rst_after got %h want %h", dutVec(), modelVec());
    end
  endtask

  task automatic test_random();
    int r;
    bit en, st, mu, su, cl;
    for (int i = 0; i < 800; i++) begin
      r  = int'($urandom_range(99));
      en = ($urandom_range(2) == 0);
      cl = (r == 99);
      st = (r >= 40 && r < 48);
      mu = (r >= 48 && r < 50);
      su = (r >= 50 && r < 70);
      if (r == 98) applyReset(1);
      else applyStimulus(en, st, mu, su, cl);
      checks++;
      if (dutVec() !== modelVec()) begin
        errors++; $display("[TB] FAIL random_%0d got %h want %h", i, dutVec(), modelVec());
      end
    end
  endtask

  initial begin
    bus.EN1HZ = 1'b0; bus.START = 1'b0; bus.MINUP = 1'b0; bus.SECUP = 1'b0; bus.CLR = 1'b0;
    modelReset();
    test_reset();
    test_set_run();
    test_alarm();
    test_pause();
    test_edges();
    test_coincident();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
